// File: rtl/span_cme_pkg.sv
// Shared types and constants for the SPAN initial-margin sequencer.
package span_cme_pkg;

    localparam int unsigned MARGIN_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_REQ,
        ST_SCAN_WAIT,
        ST_IMS_REQ,
        ST_IMS_WAIT,
        ST_SUM,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SCAN = 2'b01;
    localparam logic [1:0] ERR_IMS  = 2'b10;

endpackage

// File: rtl/phase_timer.sv
// Wait-phase cycle counter with terminal-count detect, shared by both engine phases.
module phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/span_margin_sequencer.sv
// Sequences scan-risk then inter-month engines and forms saturated initial margin.
module span_margin_sequencer
    import span_cme_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MARGIN_W       = MARGIN_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                ims_enable,
    output logic                scan_start,
    input  logic                scan_done,
    input  logic [MARGIN_W-1:0] scan_result,
    output logic                ims_start,
    input  logic                ims_done,
    input  logic [MARGIN_W-1:0] ims_result,
    output logic                busy,
    output logic                done,
    output logic [MARGIN_W-1:0] margin,
    output logic                margin_valid,
    output logic                ovf,
    output logic                error,
    output logic [1:0]          err_code
);

    seq_state_t          state;
    seq_state_t          state_next;
    logic                ims_en_q;
    logic [MARGIN_W-1:0] scan_q;
    logic [MARGIN_W-1:0] tsc_q;
    logic                timer_clear;
    logic                timer_enable;
    logic                timeout;
    logic [MARGIN_W:0]   sum_c;
    logic                accept;
    logic                aborting;

    phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .expired_c(timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_next = ST_SCAN_REQ;
            end
            ST_SCAN_REQ: begin
                timer_clear = 1'b1;
                state_next  = ST_SCAN_WAIT;
            end
            ST_SCAN_WAIT: begin
                if (scan_done)    state_next = ims_en_q ? ST_IMS_REQ : ST_SUM;
                else if (timeout) state_next = ST_DONE;
                else              timer_enable = 1'b1;
            end
            ST_IMS_REQ: begin
                timer_clear = 1'b1;
                state_next  = ST_IMS_WAIT;
            end
            ST_IMS_WAIT: begin
                if (ims_done)     state_next = ST_SUM;
                else if (timeout) state_next = ST_DONE;
                else              timer_enable = 1'b1;
            end
            ST_SUM:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // abort wins over any engine completion in the same cycle
        if (abort && (state != ST_IDLE)) state_next = ST_IDLE;
    end

    assign accept   = (state == ST_IDLE) && (state_next == ST_SCAN_REQ);
    assign aborting = abort && (state != ST_IDLE);
    assign sum_c    = {1'b0, scan_q} + {1'b0, tsc_q};

    // Output strobes are registered from next-state so they coincide with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_start   <= 1'b0;
            ims_start    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ims_en_q     <= 1'b0;
            scan_q       <= '0;
            tsc_q        <= '0;
            margin       <= '0;
            margin_valid <= 1'b0;
            ovf          <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            scan_start <= (state_next == ST_SCAN_REQ);
            ims_start  <= (state_next == ST_IMS_REQ);
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_DONE);

            if (accept) begin
                ims_en_q     <= ims_enable;
                tsc_q        <= '0;
                margin_valid <= 1'b0;
                ovf          <= 1'b0;
                error        <= 1'b0;
                err_code     <= ERR_NONE;
            end

            if (aborting) begin
                margin_valid <= 1'b0;
            end else begin
                case (state)
                    ST_SCAN_WAIT: begin
                        if (scan_done) begin
                            scan_q <= scan_result;
                        end else if (timeout) begin
                            error    <= 1'b1;
                            err_code <= ERR_SCAN;
                        end
                    end
                    ST_IMS_WAIT: begin
                        if (ims_done) begin
                            tsc_q <= ims_result;
                        end else if (timeout) begin
                            error    <= 1'b1;
                            err_code <= ERR_IMS;
                        end
                    end
                    ST_SUM: begin
                        margin       <= sum_c[MARGIN_W] ? '1 : sum_c[MARGIN_W-1:0];
                        ovf          <= sum_c[MARGIN_W];
                        margin_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
